// File: rtl/rdma_scatter_req_gen.sv
// rtl/rdma_scatter_req_gen.sv - splits a scatter request into four write descriptors and tracks their completions
module rdma_scatter_req_gen #(
  parameter int VADDR_BITS = 48,
  parameter int LEN_BITS   = 28
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [VADDR_BITS-1:0] bench_vaddr_1,
  input  logic [VADDR_BITS-1:0] bench_vaddr_2,
  input  logic [VADDR_BITS-1:0] bench_vaddr_3,
  input  logic [VADDR_BITS-1:0] bench_vaddr_4,
  input  logic                  bench_vaddr_valid,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LEN_BITS-1:0]   req_len,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [VADDR_BITS-1:0] wr_vaddr,
  output logic [LEN_BITS-1:0]   wr_len,
  output logic [1:0]            wr_idx,
  output logic                  wr_last,
  input  logic                  cmpl_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  vld_prev_q, vld_prev_d;
  logic                  armed_q, armed_d;
  logic [VADDR_BITS-1:0] tbl_q [4];
  logic [VADDR_BITS-1:0] tbl_d [4];
  logic [VADDR_BITS-1:0] snap_q [4];
  logic [VADDR_BITS-1:0] snap_d [4];
  logic [LEN_BITS-1:0]   seg_q, seg_d, len3_q, len3_d;
  logic [3:0]            mask_q, mask_d;
  logic [2:0]            exp_q, exp_d, cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [VADDR_BITS-1:0] wr_vaddr_q, wr_vaddr_d;
  logic [LEN_BITS-1:0]   wr_len_q, wr_len_d;
  logic [1:0]            wr_idx_q, wr_idx_d;
  logic                  wr_last_q, wr_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [LEN_BITS-1:0]   seg_in, len3_in;
  logic [3:0]            mask_in;
  logic [1:0]            first_p, next_p;

  // Lowest non-empty segment at or above 'from'.
  function automatic logic [1:0] next_seg(input logic [3:0] m, input logic [2:0] from);
    logic [1:0] r;
    r = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic is_last(input logic [3:0] m, input logic [1:0] idx);
    return (m >> ({1'b0, idx} + 3'd1)) == 4'd0;
  endfunction

  assign seg_in  = req_len >> 2;
  assign len3_in = seg_in + LEN_BITS'(req_len[1:0]);
  assign mask_in = {len3_in != '0, {3{seg_in != '0}}};
  assign first_p = next_seg(mask_in, 3'd0);
  assign next_p  = next_seg(mask_q, {1'b0, wr_idx_q} + 3'd1);

  always_comb begin
    state_d     = state_q;
    vld_prev_d  = bench_vaddr_valid;
    armed_d     = armed_q;
    tbl_d       = tbl_q;
    snap_d      = snap_q;
    seg_d       = seg_q;
    len3_d      = len3_q;
    mask_d      = mask_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    wr_valid_d  = wr_valid_q;
    wr_vaddr_d  = wr_vaddr_q;
    wr_len_d    = wr_len_q;
    wr_idx_d    = wr_idx_q;
    wr_last_d   = wr_last_q;

    if (bench_vaddr_valid && !vld_prev_q) begin
      tbl_d[0] = bench_vaddr_1;
      tbl_d[1] = bench_vaddr_2;
      tbl_d[2] = bench_vaddr_3;
      tbl_d[3] = bench_vaddr_4;
      armed_d  = 1'b1;
    end

    // Saturating completion count; stray pulses beyond the expected total are dropped.
    if ((state_q == S_ISSUE || state_q == S_WAIT) && cmpl_valid && (cnt_q != exp_q))
      cnt_d = cnt_q + 3'd1;

    case (state_q)
      S_IDLE: begin
        if (req_ready_q && req_valid) begin
          if (!armed_q) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (req_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ISSUE;
            snap_d     = tbl_q;
            seg_d      = seg_in;
            len3_d     = len3_in;
            mask_d     = mask_in;
            exp_d      = 3'(mask_in[0]) + 3'(mask_in[1]) + 3'(mask_in[2]) + 3'(mask_in[3]);
            cnt_d      = 3'd0;
            wr_valid_d = 1'b1;
            wr_vaddr_d = tbl_q[first_p];
            wr_len_d   = (first_p == 2'd3) ? len3_in : seg_in;
            wr_idx_d   = first_p;
            wr_last_d  = is_last(mask_in, first_p);
          end
        end
      end
      S_ISSUE: begin
        if (wr_ready) begin
          if (wr_last_q) begin
            wr_valid_d = 1'b0;
            state_d    = S_WAIT;
          end else begin
            wr_vaddr_d = snap_q[next_p];
            wr_len_d   = (next_p == 2'd3) ? len3_q : seg_q;
            wr_idx_d   = next_p;
            wr_last_d  = is_last(mask_q, next_p);
          end
        end
      end
      S_WAIT: begin
        if (cnt_d == exp_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      vld_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        tbl_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      seg_q       <= '0;
      len3_q      <= '0;
      mask_q      <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_vaddr_q  <= '0;
      wr_len_q    <= '0;
      wr_idx_q    <= '0;
      wr_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_prev_q  <= vld_prev_d;
      armed_q     <= armed_d;
      tbl_q       <= tbl_d;
      snap_q      <= snap_d;
      seg_q       <= seg_d;
      len3_q      <= len3_d;
      mask_q      <= mask_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      wr_valid_q  <= wr_valid_d;
      wr_vaddr_q  <= wr_vaddr_d;
      wr_len_q    <= wr_len_d;
      wr_idx_q    <= wr_idx_d;
      wr_last_q   <= wr_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign wr_valid  = wr_valid_q;
  assign wr_vaddr  = wr_vaddr_q;
  assign wr_len    = wr_len_q;
  assign wr_idx    = wr_idx_q;
  assign wr_last   = wr_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rdma_scatter_req_gen.sv
// tb/tb_rdma_scatter_req_gen.sv - scoreboard bench for rdma_scatter_req_gen
module tb_rdma_scatter_req_gen;

  typedef struct packed {
    logic [47:0] va;
    logic [27:0] len;
    logic [1:0]  idx;
    logic        last;
  } desc_t;

  logic        aclk, areset;
  logic [47:0] bench_vaddr_1, bench_vaddr_2, bench_vaddr_3, bench_vaddr_4;
  logic        bench_vaddr_valid, req_valid, req_ready;
  logic [27:0] req_len;
  logic        wr_valid, wr_ready;
  logic [47:0] wr_vaddr;
  logic [27:0] wr_len;
  logic [1:0]  wr_idx;
  logic        wr_last, cmpl_valid, busy, done, err;

  desc_t exp_q[$];
  int    rd_idx = 0;
  int    issued_cnt = 0, cmpl_cnt = 0;
  int    exp_done = 0, done_seen = 0;
  int    mon_pass = 0, mon_total = 0, drv_pass = 0, drv_total = 0;
  bit    wr_toggle = 0, wr_hold = 1, cmpl_auto = 1, cmpl_force = 0;

  rdma_scatter_req_gen #(.VADDR_BITS(48), .LEN_BITS(28)) dut (
    .aclk(aclk), .areset(areset),
    .bench_vaddr_1(bench_vaddr_1), .bench_vaddr_2(bench_vaddr_2),
    .bench_vaddr_3(bench_vaddr_3), .bench_vaddr_4(bench_vaddr_4),
    .bench_vaddr_valid(bench_vaddr_valid),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_vaddr(wr_vaddr),
    .wr_len(wr_len), .wr_idx(wr_idx), .wr_last(wr_last),
    .cmpl_valid(cmpl_valid), .busy(busy), .done(done), .err(err)
  );

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  // Write-ready pattern and completion responder.
  initial begin
    wr_ready = 1;
    cmpl_valid = 0;
    forever begin
      bit pend;
      @(posedge aclk);
      #1;
      wr_ready = wr_toggle ? !wr_ready : wr_hold;
      if (areset) cmpl_cnt = issued_cnt;
      pend = !areset && cmpl_auto && (issued_cnt > cmpl_cnt);
      cmpl_valid = pend || cmpl_force;
      if (pend) cmpl_cnt++;
    end
  end

  // Monitor: pops expected descriptors on handshakes, checks stall stability and done pulses.
  initial begin
    bit    prev_stall;
    desc_t prev_d, got, e;
    prev_stall = 0;
    prev_d = '0;
    forever begin
      @(negedge aclk);
      got = {wr_vaddr, wr_len, wr_idx, wr_last};
      if (areset) begin
        rd_idx = exp_q.size();
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          mon_total++;
          if (wr_valid && got == prev_d) mon_pass++;
          else $display("FAIL stall_hold: got valid=%0b %h required valid=1 %h", wr_valid, got, prev_d);
        end
        if (wr_valid && wr_ready) begin
          issued_cnt++;
          mon_total++;
          if (rd_idx >= exp_q.size()) begin
            $display("FAIL unexpected_desc: got %h required none", got);
          end else begin
            e = exp_q[rd_idx];
            rd_idx++;
            if (got == e) mon_pass++;
            else $display("FAIL desc: got va=%h len=%0d idx=%0d last=%0b required va=%h len=%0d idx=%0d last=%0b",
                          got.va, got.len, got.idx, got.last, e.va, e.len, e.idx, e.last);
          end
        end
        prev_stall = wr_valid && !wr_ready;
        prev_d = got;
        if (done) begin
          mon_total++;
          done_seen++;
          if (done_seen <= exp_done) mon_pass++;
          else $display("FAIL done_pulse: got done #%0d required at most %0d", done_seen, exp_done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    drv_total++;
    if (act === req) drv_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic push(input logic [47:0] va, input logic [27:0] len, input logic [1:0] idx, input logic last);
    desc_t d;
    d = {va, len, idx, last};
    exp_q.push_back(d);
  endtask

  task automatic push4(input logic [47:0] a0, a1, a2, a3, input logic [27:0] l012, l3);
    push(a0, l012, 2'd0, 1'b0);
    push(a1, l012, 2'd1, 1'b0);
    push(a2, l012, 2'd2, 1'b0);
    push(a3, l3,   2'd3, 1'b1);
  endtask

  task automatic arm(input logic [47:0] a0, a1, a2, a3);
    @(posedge aclk); #1;
    bench_vaddr_1 = a0; bench_vaddr_2 = a1; bench_vaddr_3 = a2; bench_vaddr_4 = a3;
    bench_vaddr_valid = 1;
    @(posedge aclk); #1;
    bench_vaddr_valid = 0;
    bench_vaddr_1 = 48'hBAD1; bench_vaddr_2 = 48'hBAD2; bench_vaddr_3 = 48'hBAD3; bench_vaddr_4 = 48'hBAD4;
  endtask

  task automatic send_req(input logic [27:0] len, input bit want_done);
    bit ok;
    int n;
    @(posedge aclk); #1;
    req_valid = 1;
    req_len = len;
    if (want_done) exp_done++;
    ok = 0;
    n = 0;
    while (!ok && n < 100) begin
      @(negedge aclk);
      ok = req_ready;
      @(posedge aclk); #1;
      n++;
    end
    req_valid = 0;
    if (!ok) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(posedge aclk); #2;
      idle = !busy && req_ready;
    end
    if (!idle) chk(name, 0, 1);
  endtask

  localparam logic [47:0] A0 = 48'h1000, A1 = 48'h2000, A2 = 48'h3000, A3 = 48'h4000;
  localparam logic [47:0] B0 = 48'h10000, B1 = 48'h20000, B2 = 48'h30000, B3 = 48'h40000;

  initial begin
    areset = 1;
    bench_vaddr_1 = 0; bench_vaddr_2 = 0; bench_vaddr_3 = 0; bench_vaddr_4 = 0;
    bench_vaddr_valid = 0;
    req_valid = 0;
    req_len = 0;
    #2;
    chk("reset_outputs", {req_ready, wr_valid, wr_vaddr, wr_len, wr_idx, wr_last, busy, done, err}, 0);
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    #2 chk("req_ready_before_edge", req_ready, 0);
    @(posedge aclk); #1;
    chk("req_ready_after_reset", req_ready, 1);

    send_req(28'd4096, 1);
    wait_idle("unarmed_timeout");
    chk("err_unarmed", err, 1);

    arm(A0, A1, A2, A3);
    push4(A0, A1, A2, A3, 28'd1024, 28'd1024);
    send_req(28'd4096, 1);
    wait_idle("len4096_timeout");

    push4(A0, A1, A2, A3, 28'd1024, 28'd1027);
    send_req(28'd4099, 1);
    wait_idle("len4099_timeout");

    push(A3, 28'd3, 2'd3, 1'b1);
    send_req(28'd3, 1);
    wait_idle("len3_timeout");

    send_req(28'd0, 1);
    wait_idle("len0_timeout");
    chk("err_sticky_len0", err, 1);

    wr_toggle = 1;
    push4(A0, A1, A2, A3, 28'd25, 28'd25);
    send_req(28'd100, 1);
    wait_idle("toggle_timeout");
    wr_toggle = 0;
    wr_hold = 1;

    @(negedge aclk) cmpl_force = 1;
    @(negedge aclk) cmpl_force = 0;
    push4(A0, A1, A2, A3, 28'd2, 28'd2);
    send_req(28'd8, 1);
    wait_idle("len8_timeout");

    push4(A0, A1, A2, A3, 28'd1024, 28'd1024);
    send_req(28'd4096, 1);
    arm(B0, B1, B2, B3);
    wait_idle("rearm_timeout");
    push4(B0, B1, B2, B3, 28'd4, 28'd4);
    send_req(28'd16, 1);
    wait_idle("new_table_timeout");

    push4(B0, B1, B2, B3, 28'd1024, 28'd1024);
    send_req(28'd4096, 0);
    @(posedge aclk);
    @(posedge aclk);
    #1 areset = 1;
    #2 chk("midreq_reset_outputs", {req_ready, wr_valid, wr_vaddr, wr_len, wr_idx, wr_last, busy, done, err}, 0);
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    @(posedge aclk); #1;
    chk("req_ready_after_midreset", req_ready, 1);
    send_req(28'd4096, 1);
    wait_idle("post_reset_timeout");
    chk("err_after_reset_unarmed", err, 1);

    repeat (3) @(posedge aclk);
    #2;
    chk("all_desc_seen", rd_idx, exp_q.size());
    chk("done_count", done_seen, exp_done);

    $display("%0d/%0d checks passed", drv_pass + mon_pass, drv_total + mon_total);
    $finish;
  end

endmodule
